// File: rtl/rf_access_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the 32x32 register file.
// The slave view belongs to the arbiter; the master view is the requester and
// register file side.
`timescale 1ns/1ps
interface rf_access_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    // Requester 0 (CPU datapath)
    logic                  REQ0;
    logic                  OP0;
    logic [ADDR_WIDTH-1:0] RADDR1_0;
    logic [ADDR_WIDTH-1:0] RADDR2_0;
    logic [ADDR_WIDTH-1:0] WADDR0;
    logic [DATA_WIDTH-1:0] WDATA0;
    logic                  ACK0;

    // Requester 1 (debug/load port)
    logic                  REQ1;
    logic                  OP1;
    logic [ADDR_WIDTH-1:0] RADDR1_1;
    logic [ADDR_WIDTH-1:0] RADDR2_1;
    logic [ADDR_WIDTH-1:0] WADDR1;
    logic [DATA_WIDTH-1:0] WDATA1;
    logic                  ACK1;

    // Shared response and status
    logic [DATA_WIDTH-1:0] RDATA1;
    logic [DATA_WIDTH-1:0] RDATA2;
    logic                  BUSY;

    // Register file side
    logic                  RF_READ;
    logic                  RF_WRITE;
    logic [ADDR_WIDTH-1:0] RF_ADDR_R1;
    logic [ADDR_WIDTH-1:0] RF_ADDR_R2;
    logic [ADDR_WIDTH-1:0] RF_ADDR_W;
    logic [DATA_WIDTH-1:0] RF_DATA_W;
    logic [DATA_WIDTH-1:0] RF_DATA_R1;
    logic [DATA_WIDTH-1:0] RF_DATA_R2;

    modport slave (
        input  REQ0, OP0, RADDR1_0, RADDR2_0, WADDR0, WDATA0,
        input  REQ1, OP1, RADDR1_1, RADDR2_1, WADDR1, WDATA1,
        input  RF_DATA_R1, RF_DATA_R2,
        output ACK0, ACK1, RDATA1, RDATA2, BUSY,
        output RF_READ, RF_WRITE, RF_ADDR_R1, RF_ADDR_R2, RF_ADDR_W, RF_DATA_W
    );

    modport master (
        output REQ0, OP0, RADDR1_0, RADDR2_0, WADDR0, WDATA0,
        output REQ1, OP1, RADDR1_1, RADDR2_1, WADDR1, WDATA1,
        output RF_DATA_R1, RF_DATA_R2,
        input  ACK0, ACK1, RDATA1, RDATA2, BUSY,
        input  RF_READ, RF_WRITE, RF_ADDR_R1, RF_ADDR_R2, RF_ADDR_W, RF_DATA_W
    );
endinterface

// File: rtl/rf_access_arbiter.sv
// Two-requester arbiter and sequencer for the dual-read register file.
// One transaction at a time: IDLE grants, ISSUE drives the file, CAPTURE
// registers clocked read data, RESP pulses the winner's ACK.
`timescale 1ns/1ps
module rf_access_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 5,
    parameter int PRIORITY_MODE = 0
) (
    input logic                CLK,
    input logic                RST,
    rf_access_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t                state;
    state_t                state_next;

    logic                  req_valid0;
    logic                  req_valid1;
    logic                  grant_any;
    logic                  grant_id;

    logic                  last;
    logic                  winner;
    logic                  op_lat;
    logic [ADDR_WIDTH-1:0] raddr1_lat;
    logic [ADDR_WIDTH-1:0] raddr2_lat;
    logic [ADDR_WIDTH-1:0] waddr_lat;
    logic [DATA_WIDTH-1:0] wdata_lat;
    logic [DATA_WIDTH-1:0] rdata1_q;
    logic [DATA_WIDTH-1:0] rdata2_q;

    // Only an exact 1 is a request, so unknown or floating lines never win
    always_comb begin
        req_valid0 = (bus.REQ0 === 1'b1);
        req_valid1 = (bus.REQ1 === 1'b1);
    end

    // Pick this cycle's winner; on a tie round-robin favours the one not served last
    always_comb begin
        grant_any = req_valid0 | req_valid1;
        grant_id  = 1'b0;
        if (req_valid0 && req_valid1) begin
            if (PRIORITY_MODE == 1) begin
                grant_id = 1'b0;
            end else begin
                grant_id = ~last;
            end
        end else if (req_valid1) begin
            grant_id = 1'b1;
        end
    end

    // State register; reset drops any in-flight transaction without an ACK
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Latch the winner's fields at grant so later input changes are ignored
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            last       <= 1'b1;
            winner     <= 1'b0;
            op_lat     <= 1'b0;
            raddr1_lat <= '0;
            raddr2_lat <= '0;
            waddr_lat  <= '0;
            wdata_lat  <= '0;
        end else if ((state == IDLE) && grant_any) begin
            last   <= grant_id;
            winner <= grant_id;
            if (grant_id) begin
                op_lat     <= bus.OP1;
                raddr1_lat <= bus.RADDR1_1;
                raddr2_lat <= bus.RADDR2_1;
                waddr_lat  <= bus.WADDR1;
                wdata_lat  <= bus.WDATA1;
            end else begin
                op_lat     <= bus.OP0;
                raddr1_lat <= bus.RADDR1_0;
                raddr2_lat <= bus.RADDR2_0;
                waddr_lat  <= bus.WADDR0;
                wdata_lat  <= bus.WDATA0;
            end
        end
    end

    // Register the file's clocked read data at the end of CAPTURE; held until the next read
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rdata1_q <= '0;
            rdata2_q <= '0;
        end else if (state == CAPTURE) begin
            rdata1_q <= bus.RF_DATA_R1;
            rdata2_q <= bus.RF_DATA_R2;
        end
    end

    // Sequence the transaction and drive the register file and ACK lines
    always_comb begin
        state_next     = state;
        bus.RF_READ    = 1'b0;
        bus.RF_WRITE   = 1'b0;
        bus.RF_ADDR_R1 = '0;
        bus.RF_ADDR_R2 = '0;
        bus.RF_ADDR_W  = '0;
        bus.RF_DATA_W  = '0;
        bus.ACK0       = 1'b0;
        bus.ACK1       = 1'b0;
        case (state)
            IDLE: begin
                if (grant_any) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (op_lat) begin
                    bus.RF_WRITE  = 1'b1;
                    bus.RF_ADDR_W = waddr_lat;
                    bus.RF_DATA_W = wdata_lat;
                    state_next    = RESP;
                end else begin
                    bus.RF_READ    = 1'b1;
                    bus.RF_ADDR_R1 = raddr1_lat;
                    bus.RF_ADDR_R2 = raddr2_lat;
                    state_next     = CAPTURE;
                end
            end
            CAPTURE: begin
                bus.RF_READ    = 1'b1;
                bus.RF_ADDR_R1 = raddr1_lat;
                bus.RF_ADDR_R2 = raddr2_lat;
                state_next     = RESP;
            end
            RESP: begin
                bus.ACK0   = ~winner;
                bus.ACK1   = winner;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.BUSY   = (state != IDLE);
    assign bus.RDATA1 = rdata1_q;
    assign bus.RDATA2 = rdata2_q;

endmodule

// File: tb/tb_rf_access_arbiter.sv
// Directed bench for rf_access_arbiter: a round-robin instance wired to a
// behavioural register file, plus a fixed-priority instance for the tie case.
`timescale 1ns/1ps
module tb_rf_access_arbiter;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    int   compared   = 0;
    int   mismatched = 0;

    rf_access_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) mif ();
    rf_access_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) pif ();

    rf_access_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .PRIORITY_MODE(0)) dut_rr (
        .CLK (CLK),
        .RST (RST),
        .bus (mif)
    );

    rf_access_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .PRIORITY_MODE(1)) dut_pri (
        .CLK (CLK),
        .RST (RST),
        .bus (pif)
    );

    always #5 CLK = ~CLK;

    // Behavioural 32x32 register file: clocked read, data valid while READ is high
    logic [31:0] rf_mem [32];
    logic [31:0] rf_q1;
    logic [31:0] rf_q2;

    // Register file storage, cleared with the system reset
    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= '0;
            rf_q1 <= '0;
            rf_q2 <= '0;
        end else begin
            if (mif.RF_WRITE) rf_mem[mif.RF_ADDR_W] <= mif.RF_DATA_W;
            if (mif.RF_READ) begin
                rf_q1 <= rf_mem[mif.RF_ADDR_R1];
                rf_q2 <= rf_mem[mif.RF_ADDR_R2];
            end
        end
    end

    assign mif.RF_DATA_R1 = mif.RF_READ ? rf_q1 : 32'h0;
    assign mif.RF_DATA_R2 = mif.RF_READ ? rf_q2 : 32'h0;
    assign pif.RF_DATA_R1 = 32'h0;
    assign pif.RF_DATA_R2 = 32'h0;

    task automatic step_cycle();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic clear_requests();
        mif.REQ0 = 1'b0; mif.OP0 = 1'b0; mif.RADDR1_0 = '0; mif.RADDR2_0 = '0;
        mif.WADDR0 = '0; mif.WDATA0 = '0;
        mif.REQ1 = 1'b0; mif.OP1 = 1'b0; mif.RADDR1_1 = '0; mif.RADDR2_1 = '0;
        mif.WADDR1 = '0; mif.WDATA1 = '0;
        pif.REQ0 = 1'b0; pif.OP0 = 1'b0; pif.RADDR1_0 = '0; pif.RADDR2_0 = '0;
        pif.WADDR0 = '0; pif.WDATA0 = '0;
        pif.REQ1 = 1'b0; pif.OP1 = 1'b0; pif.RADDR1_1 = '0; pif.RADDR2_1 = '0;
        pif.WADDR1 = '0; pif.WDATA1 = '0;
    endtask

    task automatic test_reset();
        clear_requests();
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        compared++;
        if ({mif.ACK0, mif.ACK1, mif.BUSY} !== 3'b000) begin
            mismatched++;
            $display("[TB] FAIL reset_ack_busy: got %b expected %b", {mif.ACK0, mif.ACK1, mif.BUSY}, 3'b000);
        end
        compared++;
        if ({mif.RF_READ, mif.RF_WRITE} !== 2'b00) begin
            mismatched++;
            $display("[TB] FAIL reset_rf_ctrl: got %b expected %b", {mif.RF_READ, mif.RF_WRITE}, 2'b00);
        end
        compared++;
        if ({mif.RF_ADDR_R1, mif.RF_ADDR_R2, mif.RF_ADDR_W} !== 15'h0) begin
            mismatched++;
            $display("[TB] FAIL reset_rf_addr: got %h expected %h", {mif.RF_ADDR_R1, mif.RF_ADDR_R2, mif.RF_ADDR_W}, 15'h0);
        end
        compared++;
        if ({mif.RF_DATA_W, mif.RDATA1, mif.RDATA2} !== 96'h0) begin
            mismatched++;
            $display("[TB] FAIL reset_data: got %h expected %h", {mif.RF_DATA_W, mif.RDATA1, mif.RDATA2}, 96'h0);
        end
        compared++;
        if ({pif.ACK0, pif.ACK1, pif.BUSY} !== 3'b000) begin
            mismatched++;
            $display("[TB] FAIL reset_pri_ack_busy: got %b expected %b", {pif.ACK0, pif.ACK1, pif.BUSY}, 3'b000);
        end
        RST = 1'b1;
        step_cycle();
        compared++;
        if (mif.BUSY !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL idle_after_reset_busy: got %b expected %b", mif.BUSY, 1'b0);
        end
    endtask

    task automatic test_single_write();
        int ack_k;
        int wr_cycles;
        int bad_wr;
        ack_k = 0; wr_cycles = 0; bad_wr = 0;
        mif.OP0 = 1'b1; mif.WADDR0 = 5'd5; mif.WDATA0 = 32'hDEADBEEF; mif.REQ0 = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step_cycle();
            if (mif.RF_WRITE === 1'b1) begin
                wr_cycles++;
                if (mif.RF_ADDR_W !== 5'd5 || mif.RF_DATA_W !== 32'hDEADBEEF) bad_wr++;
            end
            if (mif.ACK1 === 1'b1 || mif.RF_READ === 1'b1) bad_wr++;
            if (mif.ACK0 === 1'b1) begin
                ack_k = k;
                mif.REQ0 = 1'b0;
                break;
            end
        end
        compared++;
        if (ack_k !== 2) begin
            mismatched++;
            $display("[TB] FAIL write_ack_latency: got %0d expected %0d", ack_k, 2);
        end
        compared++;
        if (wr_cycles !== 1) begin
            mismatched++;
            $display("[TB] FAIL write_rf_write_cycles: got %0d expected %0d", wr_cycles, 1);
        end
        compared++;
        if (bad_wr !== 0) begin
            mismatched++;
            $display("[TB] FAIL write_rf_lines: got %0d bad cycles expected %0d", bad_wr, 0);
        end
        step_cycle();
        compared++;
        if ({mif.BUSY, mif.ACK0} !== 2'b00) begin
            mismatched++;
            $display("[TB] FAIL write_return_idle: got %b expected %b", {mif.BUSY, mif.ACK0}, 2'b00);
        end
    endtask

    task automatic test_read_back();
        int          ack_k;
        int          rd_cycles;
        int          bad_rd;
        logic [31:0] got1;
        logic [31:0] got2;
        ack_k = 0; rd_cycles = 0; bad_rd = 0; got1 = 32'h1; got2 = 32'h1;
        mif.OP1 = 1'b0; mif.RADDR1_1 = 5'd5; mif.RADDR2_1 = 5'd0; mif.REQ1 = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step_cycle();
            if (mif.RF_READ === 1'b1) begin
                rd_cycles++;
                if (mif.RF_ADDR_R1 !== 5'd5 || mif.RF_ADDR_R2 !== 5'd0) bad_rd++;
            end
            if (mif.RF_WRITE === 1'b1 || mif.ACK0 === 1'b1) bad_rd++;
            if (mif.ACK1 === 1'b1) begin
                ack_k = k;
                got1 = mif.RDATA1;
                got2 = mif.RDATA2;
                mif.REQ1 = 1'b0;
                break;
            end
        end
        compared++;
        if (ack_k !== 3) begin
            mismatched++;
            $display("[TB] FAIL read_ack_latency: got %0d expected %0d", ack_k, 3);
        end
        compared++;
        if (got1 !== 32'hDEADBEEF) begin
            mismatched++;
            $display("[TB] FAIL read_rdata1: got %h expected %h", got1, 32'hDEADBEEF);
        end
        compared++;
        if (got2 !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL read_rdata2: got %h expected %h", got2, 32'h0);
        end
        compared++;
        if (rd_cycles !== 2) begin
            mismatched++;
            $display("[TB] FAIL read_rf_read_cycles: got %0d expected %0d", rd_cycles, 2);
        end
        compared++;
        if (bad_rd !== 0) begin
            mismatched++;
            $display("[TB] FAIL read_rf_lines: got %0d bad cycles expected %0d", bad_rd, 0);
        end
        step_cycle();
    endtask

    task automatic test_round_robin();
        int n;
        int overlap;
        n = 0; overlap = 0;
        mif.OP0 = 1'b0; mif.RADDR1_0 = 5'd5; mif.RADDR2_0 = 5'd5;
        mif.OP1 = 1'b0; mif.RADDR1_1 = 5'd0; mif.RADDR2_1 = 5'd5;
        mif.REQ0 = 1'b1; mif.REQ1 = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            step_cycle();
            if (mif.ACK0 === 1'b1 && mif.ACK1 === 1'b1) overlap++;
            if (mif.ACK0 === 1'b1 || mif.ACK1 === 1'b1) begin
                compared++;
                if (mif.ACK1 !== n[0] || k !== 3 + 4 * n) begin
                    mismatched++;
                    $display("[TB] FAIL rr_grant%0d: got ack1=%b at edge %0d expected ack1=%b at edge %0d",
                             n, mif.ACK1, k, n[0], 3 + 4 * n);
                end
                compared++;
                if (n[0] == 1'b0 && {mif.RDATA1, mif.RDATA2} !== {32'hDEADBEEF, 32'hDEADBEEF}) begin
                    mismatched++;
                    $display("[TB] FAIL rr_rdata_req0_%0d: got %h expected %h", n, {mif.RDATA1, mif.RDATA2},
                             {32'hDEADBEEF, 32'hDEADBEEF});
                end else if (n[0] == 1'b1 && {mif.RDATA1, mif.RDATA2} !== {32'h0, 32'hDEADBEEF}) begin
                    mismatched++;
                    $display("[TB] FAIL rr_rdata_req1_%0d: got %h expected %h", n, {mif.RDATA1, mif.RDATA2},
                             {32'h0, 32'hDEADBEEF});
                end
                n++;
                if (n == 4) begin
                    mif.REQ0 = 1'b0;
                    mif.REQ1 = 1'b0;
                    break;
                end
            end
        end
        compared++;
        if (n !== 4) begin
            mismatched++;
            $display("[TB] FAIL rr_transaction_count: got %0d expected %0d", n, 4);
        end
        compared++;
        if (overlap !== 0) begin
            mismatched++;
            $display("[TB] FAIL rr_ack_overlap: got %0d expected %0d", overlap, 0);
        end
        mif.REQ0 = 1'b0;
        mif.REQ1 = 1'b0;
        step_cycle();
    endtask

    task automatic test_priority();
        int n0;
        int early;
        int ack1_k;
        logic req0_high;
        n0 = 0; early = 0; ack1_k = 0; req0_high = 1'b1;
        pif.OP0 = 1'b0; pif.OP1 = 1'b0;
        pif.REQ0 = 1'b1; pif.REQ1 = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            step_cycle();
            if (pif.ACK1 === 1'b1 && req0_high) early++;
            if (pif.ACK0 === 1'b1) begin
                n0++;
                if (n0 == 3) begin
                    pif.REQ0 = 1'b0;
                    req0_high = 1'b0;
                end
            end
            if (pif.ACK1 === 1'b1 && !req0_high) begin
                ack1_k = k;
                pif.REQ1 = 1'b0;
                break;
            end
        end
        compared++;
        if (n0 !== 3) begin
            mismatched++;
            $display("[TB] FAIL pri_req0_grants: got %0d expected %0d", n0, 3);
        end
        compared++;
        if (early !== 0) begin
            mismatched++;
            $display("[TB] FAIL pri_ack1_while_req0: got %0d expected %0d", early, 0);
        end
        compared++;
        if (ack1_k !== 15) begin
            mismatched++;
            $display("[TB] FAIL pri_ack1_edge: got %0d expected %0d", ack1_k, 15);
        end
        pif.REQ0 = 1'b0;
        pif.REQ1 = 1'b0;
        step_cycle();
    endtask

    task automatic test_reset_mid_read();
        int          ack_seen;
        int          ack_k;
        logic [31:0] got1;
        logic [31:0] got2;
        ack_seen = 0; ack_k = 0; got1 = 32'h1; got2 = 32'h1;
        mif.OP0 = 1'b0; mif.RADDR1_0 = 5'd5; mif.RADDR2_0 = 5'd5; mif.REQ0 = 1'b1;
        step_cycle();
        step_cycle();
        compared++;
        if ({mif.BUSY, mif.RF_READ, mif.ACK0} !== 3'b110) begin
            mismatched++;
            $display("[TB] FAIL midread_in_capture: got %b expected %b", {mif.BUSY, mif.RF_READ, mif.ACK0}, 3'b110);
        end
        RST = 1'b0;
        mif.REQ0 = 1'b0;
        #1;
        compared++;
        if ({mif.ACK0, mif.ACK1, mif.BUSY, mif.RF_READ, mif.RF_WRITE} !== 5'b00000) begin
            mismatched++;
            $display("[TB] FAIL midread_reset_ctrl: got %b expected %b",
                     {mif.ACK0, mif.ACK1, mif.BUSY, mif.RF_READ, mif.RF_WRITE}, 5'b00000);
        end
        compared++;
        if ({mif.RF_ADDR_R1, mif.RF_ADDR_R2, mif.RF_ADDR_W} !== 15'h0) begin
            mismatched++;
            $display("[TB] FAIL midread_reset_addr: got %h expected %h",
                     {mif.RF_ADDR_R1, mif.RF_ADDR_R2, mif.RF_ADDR_W}, 15'h0);
        end
        compared++;
        if ({mif.RDATA1, mif.RDATA2, mif.RF_DATA_W} !== 96'h0) begin
            mismatched++;
            $display("[TB] FAIL midread_reset_data: got %h expected %h", {mif.RDATA1, mif.RDATA2, mif.RF_DATA_W}, 96'h0);
        end
        for (int k = 0; k < 4; k++) begin
            step_cycle();
            if (k == 1) RST = 1'b1;
            if (mif.ACK0 === 1'b1 || mif.ACK1 === 1'b1) ack_seen++;
        end
        compared++;
        if (ack_seen !== 0) begin
            mismatched++;
            $display("[TB] FAIL midread_dropped_ack: got %0d acks expected %0d", ack_seen, 0);
        end
        mif.OP1 = 1'b0; mif.RADDR1_1 = 5'd5; mif.RADDR2_1 = 5'd5; mif.REQ1 = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step_cycle();
            if (mif.ACK1 === 1'b1) begin
                ack_k = k;
                got1 = mif.RDATA1;
                got2 = mif.RDATA2;
                mif.REQ1 = 1'b0;
                break;
            end
        end
        compared++;
        if (ack_k !== 3) begin
            mismatched++;
            $display("[TB] FAIL postreset_read_latency: got %0d expected %0d", ack_k, 3);
        end
        compared++;
        if ({got1, got2} !== 64'h0) begin
            mismatched++;
            $display("[TB] FAIL postreset_read_data: got %h expected %h", {got1, got2}, 64'h0);
        end
        mif.REQ1 = 1'b0;
        step_cycle();
    endtask

    task automatic test_x_request();
        mif.REQ0 = 1'bx;
        mif.REQ1 = 1'b0;
        mif.OP0  = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step_cycle();
            compared++;
            if ({mif.BUSY, mif.RF_READ, mif.RF_WRITE, mif.ACK0} !== 4'b0000) begin
                mismatched++;
                $display("[TB] FAIL xreq_cycle%0d: got %b expected %b", k,
                         {mif.BUSY, mif.RF_READ, mif.RF_WRITE, mif.ACK0}, 4'b0000);
            end
        end
        mif.REQ0 = 1'b0;
        mif.OP0  = 1'b0;
    endtask

    // Run every scenario in order, then report
    initial begin
        $display("[TB] rf_access_arbiter directed bench start");
        test_reset();
        test_single_write();
        test_read_back();
        test_round_robin();
        test_priority();
        test_reset_mid_read();
        test_x_request();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
